// File: rtl/bp_cfg_responder.sv
// Responder side of the per-tile configuration link: one request in flight, one response per request.
// Holds the tile's runtime configuration registers and drives them straight out to the core, LCE and CCE.
module bp_cfg_responder #(
  parameter int          cfg_addr_width_p = 16,
  parameter int          cfg_data_width_p = 32,
  parameter int          core_id_width_p  = 4,
  parameter logic        default_freeze_p = 1'b1,
  parameter logic [31:0] hw_id_p          = 32'hB9A0_0001
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        cfg_v_i,
  input  logic                        cfg_w_i,
  input  logic [cfg_addr_width_p-1:0] cfg_addr_i,
  input  logic [cfg_data_width_p-1:0] cfg_data_i,
  output logic                        cfg_ready_o,
  output logic                        resp_v_o,
  output logic [cfg_data_width_p-1:0] resp_data_o,
  output logic                        resp_err_o,
  input  logic                        resp_ready_i,
  output logic                        freeze_o,
  output logic [core_id_width_p-1:0]  core_id_o,
  output logic [1:0]                  icache_mode_o,
  output logic [1:0]                  dcache_mode_o,
  output logic                        cce_mode_o,
  output logic [7:0]                  domain_mask_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  localparam logic [cfg_data_width_p-1:0] hw_id_lp = cfg_data_width_p'(hw_id_p);

  logic [0:0]                  state;
  logic [cfg_data_width_p-1:0] scratch;

  logic [cfg_data_width_p-1:0] rd_data;
  logic                        req_err;
  logic                        mapped;
  logic [2:0]                  sel;
  logic                        wr_freeze, wr_core_id, wr_icache, wr_dcache, wr_cce, wr_domain, wr_scratch;

  assign cfg_ready_o = (state == IDLE) && !reset_i;
  assign resp_v_o    = (state == RESP);

  assign mapped = (cfg_addr_i < cfg_addr_width_p'(8));
  assign sel    = cfg_addr_i[2:0];

  // Decode of the request as presented; only consumed on the accept edge.
  always_comb begin
    rd_data    = '0;
    req_err    = 1'b0;
    wr_freeze  = 1'b0;
    wr_core_id = 1'b0;
    wr_icache  = 1'b0;
    wr_dcache  = 1'b0;
    wr_cce     = 1'b0;
    wr_domain  = 1'b0;
    wr_scratch = 1'b0;
    if (!mapped) begin
      req_err = 1'b1;
    end else begin
      case (sel)
        3'd0: begin
          rd_data   = cfg_data_width_p'(freeze_o);
          wr_freeze = cfg_w_i;
        end
        3'd1: begin
          rd_data    = cfg_data_width_p'(core_id_o);
          req_err    = cfg_w_i && !freeze_o;
          wr_core_id = cfg_w_i && freeze_o;
        end
        3'd2: begin
          rd_data   = cfg_data_width_p'(icache_mode_o);
          req_err   = cfg_w_i && (!freeze_o || (cfg_data_i[1:0] == 2'd3));
          wr_icache = cfg_w_i && !req_err;
        end
        3'd3: begin
          rd_data   = cfg_data_width_p'(dcache_mode_o);
          req_err   = cfg_w_i && (!freeze_o || (cfg_data_i[1:0] == 2'd3));
          wr_dcache = cfg_w_i && !req_err;
        end
        3'd4: begin
          rd_data = cfg_data_width_p'(cce_mode_o);
          req_err = cfg_w_i && !freeze_o;
          wr_cce  = cfg_w_i && freeze_o;
        end
        3'd5: begin
          rd_data   = cfg_data_width_p'(domain_mask_o);
          wr_domain = cfg_w_i;
        end
        3'd6: begin
          rd_data    = scratch;
          wr_scratch = cfg_w_i;
        end
        default: begin
          rd_data = hw_id_lp;
          req_err = cfg_w_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= IDLE;
      freeze_o      <= default_freeze_p;
      core_id_o     <= '0;
      icache_mode_o <= 2'd0;
      dcache_mode_o <= 2'd0;
      cce_mode_o    <= 1'b0;
      domain_mask_o <= 8'h01;
      scratch       <= '0;
      resp_data_o   <= '0;
      resp_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_v_i) begin
            state       <= RESP;
            resp_err_o  <= req_err;
            resp_data_o <= (req_err || cfg_w_i) ? '0 : rd_data;
            if (wr_freeze)  freeze_o      <= cfg_data_i[0];
            if (wr_core_id) core_id_o     <= cfg_data_i[core_id_width_p-1:0];
            if (wr_icache)  icache_mode_o <= cfg_data_i[1:0];
            if (wr_dcache)  dcache_mode_o <= cfg_data_i[1:0];
            if (wr_cce)     cce_mode_o    <= cfg_data_i[0];
            if (wr_domain)  domain_mask_o <= cfg_data_i[7:0];
            if (wr_scratch) scratch       <= cfg_data_i;
          end
        end
        default: begin
          if (resp_ready_i) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_responder.sv
// Scoreboard bench for bp_cfg_responder: directed scenarios, then randomized traffic with random response backpressure.
module tb_bp_cfg_responder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cfg_v_i, cfg_w_i;
  logic [15:0] cfg_addr_i;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_o, resp_v_o, resp_err_o, resp_ready_i;
  logic [31:0] resp_data_o;
  logic        freeze_o, cce_mode_o;
  logic [3:0]  core_id_o;
  logic [1:0]  icache_mode_o, dcache_mode_o;
  logic [7:0]  domain_mask_o;

  bp_cfg_responder dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cfg_v_i(cfg_v_i), .cfg_w_i(cfg_w_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_ready_o(cfg_ready_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .resp_err_o(resp_err_o), .resp_ready_i(resp_ready_i),
    .freeze_o(freeze_o), .core_id_o(core_id_o), .icache_mode_o(icache_mode_o),
    .dcache_mode_o(dcache_mode_o), .cce_mode_o(cce_mode_o), .domain_mask_o(domain_mask_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int n_issued = 0;
  int n_accepted = 0;
  bit rand_rdy = 0;

  logic [32:0] exp_q[$];  // {err, data}

  // Reference register file, indexed by address
  logic        m_freeze;
  logic [3:0]  m_core;
  logic [1:0]  m_ic, m_dc;
  logic        m_cce;
  logic [7:0]  m_dom;
  logic [31:0] m_scr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_freeze = 1'b1; m_core = 4'd0; m_ic = 2'd0; m_dc = 2'd0;
    m_cce = 1'b0; m_dom = 8'h01; m_scr = 32'd0;
  endtask

  task automatic model_accept(input logic w, input logic [15:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        err;
    rd = 32'd0;
    err = 1'b0;
    if (a > 16'd7) err = 1'b1;
    else if (!w) begin
      case (a)
        16'd0: rd = {31'd0, m_freeze};
        16'd1: rd = {28'd0, m_core};
        16'd2: rd = {30'd0, m_ic};
        16'd3: rd = {30'd0, m_dc};
        16'd4: rd = {31'd0, m_cce};
        16'd5: rd = {24'd0, m_dom};
        16'd6: rd = m_scr;
        default: rd = 32'hB9A0_0001;
      endcase
    end else begin
      if (a == 16'd7) err = 1'b1;
      else if (a >= 16'd1 && a <= 16'd4 && !m_freeze) err = 1'b1;
      else if ((a == 16'd2 || a == 16'd3) && d[1:0] == 2'd3) err = 1'b1;
      else begin
        case (a)
          16'd0: m_freeze = d[0];
          16'd1: m_core = d[3:0];
          16'd2: m_ic = d[1:0];
          16'd3: m_dc = d[1:0];
          16'd4: m_cce = d[0];
          16'd5: m_dom = d[7:0];
          default: m_scr = d;
        endcase
      end
    end
    exp_q.push_back({err, rd});
  endtask

  task automatic check_cfg(input string tag);
    chk({tag, ".freeze"}, {31'd0, freeze_o}, {31'd0, m_freeze});
    chk({tag, ".core_id"}, {28'd0, core_id_o}, {28'd0, m_core});
    chk({tag, ".icache"}, {30'd0, icache_mode_o}, {30'd0, m_ic});
    chk({tag, ".dcache"}, {30'd0, dcache_mode_o}, {30'd0, m_dc});
    chk({tag, ".cce"}, {31'd0, cce_mode_o}, {31'd0, m_cce});
    chk({tag, ".domain"}, {24'd0, domain_mask_o}, {24'd0, m_dom});
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d);
    int budget;
    budget = 0;
    cfg_v_i = 1'b1; cfg_w_i = w; cfg_addr_i = a; cfg_data_i = d;
    while (!cfg_ready_o && budget < 60) begin
      @(posedge clk_i); #1;
      budget++;
    end
    if (!cfg_ready_o) begin
      errors++; checks++;
      $display("FAIL accept_timeout: cfg_ready_o=%b expected 1 at %0t", cfg_ready_o, $time);
      cfg_v_i = 1'b0;
      return;
    end
    model_accept(w, a, d);
    n_issued++;
    @(posedge clk_i); #1;
    cfg_v_i = 1'b0;
    chk("resp_latency", {31'd0, resp_v_o}, 32'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || resp_v_o) && budget < 60) begin
      @(posedge clk_i); #1;
      budget++;
    end
    chk("drain_q", exp_q.size(), 0);
  endtask

  // Monitor: compares the presented response every cycle, pops on handshake.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (cfg_v_i && cfg_ready_o) n_accepted++;
      if (cfg_ready_o && resp_v_o) begin
        errors++; checks++;
        $display("FAIL ready_and_resp: cfg_ready_o=%b resp_v_o=%b expected not both", cfg_ready_o, resp_v_o);
      end
      if (resp_v_o) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_resp: data=%h err=%b expected none", resp_data_o, resp_err_o);
        end else begin
          chk("resp_data", resp_data_o, exp_q[0][31:0]);
          chk("resp_err", {31'd0, resp_err_o}, {31'd0, exp_q[0][32]});
          if (resp_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (rand_rdy) resp_ready_i = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [31:0] d;
    reset_i = 1'b1; cfg_v_i = 1'b0; cfg_w_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    resp_ready_i = 1'b1;
    model_reset();
    #12;
    chk("rst.cfg_ready", {31'd0, cfg_ready_o}, 32'd0);
    chk("rst.resp_v", {31'd0, resp_v_o}, 32'd0);
    chk("rst.resp_data", resp_data_o, 32'd0);
    check_cfg("rst");
    @(posedge clk_i); #1; reset_i = 1'b0;
    @(posedge clk_i); #1;

    issue(1'b0, 16'h0000, 32'h0);
    issue(1'b0, 16'h0007, 32'h0);
    drain();

    issue(1'b1, 16'h0002, 32'h1);
    issue(1'b1, 16'h0001, 32'h5);
    issue(1'b1, 16'h0000, 32'h0);
    drain();
    check_cfg("unfreeze");
    chk("core_id5", {28'd0, core_id_o}, 32'd5);
    issue(1'b1, 16'h0003, 32'h1);
    drain();
    check_cfg("mode_while_run");

    issue(1'b1, 16'h0000, 32'h1);
    issue(1'b1, 16'h0003, 32'h3);
    issue(1'b1, 16'h0006, 32'hDEAD_BEEF);
    issue(1'b0, 16'h0006, 32'h0);
    drain();
    check_cfg("mode3");

    // Backpressure: response held while a new request waits
    resp_ready_i = 1'b0;
    issue(1'b0, 16'h0006, 32'h0);
    cfg_v_i = 1'b1; cfg_w_i = 1'b0; cfg_addr_i = 16'h0005; cfg_data_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("stall.cfg_ready", {31'd0, cfg_ready_o}, 32'd0);
      chk("stall.resp_v", {31'd0, resp_v_o}, 32'd1);
    end
    resp_ready_i = 1'b1;
    issue(1'b0, 16'h0005, 32'h0);
    drain();
    chk("stall.accepts", n_accepted, n_issued);

    issue(1'b0, 16'h0010, 32'h0);
    issue(1'b1, 16'h0007, 32'h1234_5678);
    issue(1'b1, 16'h0005, 32'hFFFF_FF0C);
    drain();
    check_cfg("errs");
    chk("domain_0c", {24'd0, domain_mask_o}, 32'h0C);

    // Reset while a response is pending
    resp_ready_i = 1'b0;
    issue(1'b1, 16'h0005, 32'h33);
    reset_i = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    chk("midrst.resp_v", {31'd0, resp_v_o}, 32'd0);
    chk("midrst.domain", {24'd0, domain_mask_o}, 32'h01);
    chk("midrst.cfg_ready", {31'd0, cfg_ready_o}, 32'd0);
    @(posedge clk_i); #1; reset_i = 1'b0; resp_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    chk("midrst.no_resp", {31'd0, resp_v_o}, 32'd0);
    check_cfg("midrst");
    n_accepted = n_issued;

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 16'h0010 + 16'($urandom_range(0, 255));
        1:       a = 16'hFFFF;
        default: a = 16'($urandom_range(0, 7));
      endcase
      d = $urandom;
      if ($urandom_range(0, 4) == 0) d[1:0] = 2'd3;
      issue(1'($urandom_range(0, 1)), a, d);
      if (i % 25 == 24) check_cfg("rand");
    end
    rand_rdy = 1'b0;
    @(posedge clk_i); #2;
    resp_ready_i = 1'b1;
    drain();
    check_cfg("final");
    chk("total_accepts", n_accepted, n_issued);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
